// File: rtl/arp_crypto_input_arbiter.sv
// Purpose: packet-atomic two-input round-robin AXI-Stream arbiter with per-port packet counters.
// Latency: one bubble cycle (IDLE) per packet, then a zero-latency combinational mux per beat.
// Backpressure: m_axis_tready passes straight to the granted port; the other port sees tready=0.
module arp_crypto_input_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s0_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s0_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s0_axis_tuser,
    input  logic                              s0_axis_tvalid,
    output logic                              s0_axis_tready,
    input  logic                              s0_axis_tlast,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s1_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s1_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s1_axis_tuser,
    input  logic                              s1_axis_tvalid,
    output logic                              s1_axis_tready,
    input  logic                              s1_axis_tlast,

    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,

    input  logic [1:0]                        port_en,
    input  logic                              cnt_clear,
    output logic [C_CNT_WIDTH-1:0]            pkt_cnt0,
    output logic [C_CNT_WIDTH-1:0]            pkt_cnt1,
    output logic                              grant,
    output logic                              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       grant_q;
    logic       grant_nxt;
    logic       last_grant;
    logic       last_grant_nxt;
    logic [1:0] req;
    logic       pkt_done;

    assign req   = {s1_axis_tvalid & port_en[1], s0_axis_tvalid & port_en[0]};
    assign grant = grant_q;
    assign busy  = (state == PKT);

    // Data-path mux follows the held grant; only tvalid/tready are gated by state.
    always_comb begin
        m_axis_tdata = grant_q ? s1_axis_tdata : s0_axis_tdata;
        m_axis_tkeep = grant_q ? s1_axis_tkeep : s0_axis_tkeep;
        m_axis_tuser = grant_q ? s1_axis_tuser : s0_axis_tuser;
        m_axis_tlast = grant_q ? s1_axis_tlast : s0_axis_tlast;
    end

    // Next-state, grant selection and handshake gating.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_q;
        last_grant_nxt = last_grant;
        m_axis_tvalid  = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        pkt_done       = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    // Round robin: the port after last_grant gets first pick.
                    if (last_grant) begin
                        grant_nxt = req[0] ? 1'b0 : 1'b1;
                    end else begin
                        grant_nxt = req[1] ? 1'b1 : 1'b0;
                    end
                    state_nxt = PKT;
                end
            end
            PKT: begin
                m_axis_tvalid  = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
                s0_axis_tready = ~grant_q & m_axis_tready;
                s1_axis_tready =  grant_q & m_axis_tready;
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    pkt_done       = 1'b1;
                    last_grant_nxt = grant_q;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state      <= IDLE;
            grant_q    <= 1'b1;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            grant_q    <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Per-port packet counters; clear beats a coincident increment.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset || cnt_clear) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (pkt_done) begin
            if (grant_q) begin
                pkt_cnt1 <= pkt_cnt1 + 1'b1;
            end else begin
                pkt_cnt0 <= pkt_cnt0 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arp_crypto_input_arbiter.sv
// Purpose: randomized self-checking bench for arp_crypto_input_arbiter against a packet-level model.
// Latency: model expects one idle cycle before the first beat of each packet.
// Backpressure: sources hold beats until accepted; sink ready is constant, patterned or random.
module tb_arp_crypto_input_arbiter;

    localparam int DW = 32;
    localparam int UW = 16;
    localparam int KW = DW / 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          axis_reset;
    logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic [KW-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
    logic [UW-1:0] s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
    logic          s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
    logic          s0_axis_tready, s1_axis_tready, m_axis_tready;
    logic          s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
    logic [1:0]    port_en;
    logic          cnt_clear;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;
    logic          grant, busy;

    always #5 clk = ~clk;

    arp_crypto_input_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_CNT_WIDTH       (CW)
    ) dut (
        .axis_aclk     (clk),
        .axis_reset    (axis_reset),
        .s0_axis_tdata (s0_axis_tdata),
        .s0_axis_tkeep (s0_axis_tkeep),
        .s0_axis_tuser (s0_axis_tuser),
        .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tready(s0_axis_tready),
        .s0_axis_tlast (s0_axis_tlast),
        .s1_axis_tdata (s1_axis_tdata),
        .s1_axis_tkeep (s1_axis_tkeep),
        .s1_axis_tuser (s1_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tready(s1_axis_tready),
        .s1_axis_tlast (s1_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .port_en       (port_en),
        .cnt_clear     (cnt_clear),
        .pkt_cnt0      (pkt_cnt0),
        .pkt_cnt1      (pkt_cnt1),
        .grant         (grant),
        .busy          (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Source beat queues; head is the beat currently (or next) offered.
    beat_t q0[$];
    beat_t q1[$];

    // Stimulus controls.
    logic [1:0] en_v        = 2'b11;
    int         rdy_mode    = 0;      // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    int         pat_idx     = 0;
    bit         rnd_vld     = 1'b0;
    bit         rnd_clr     = 1'b0;
    bit         rnd_en      = 1'b0;
    bit         clr_on_last = 1'b0;
    bit         rst_req     = 1'b0;
    bit         flush       = 1'b0;
    bit         hs0         = 1'b0;
    bit         hs1         = 1'b0;

    // Packet-level reference model.
    bit         busy_m      = 1'b0;
    bit         port_m      = 1'b0;
    bit         last_m      = 1'b1;
    int         cnt0_m      = 0;
    int         cnt1_m      = 0;
    int         fwd_beats   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_pkt(input bit p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = {p, 7'(i), 24'($urandom)};
            b.k = 4'($urandom);
            b.u = 16'($urandom);
            b.l = (i == len - 1);
            if (p) q1.push_back(b);
            else   q0.push_back(b);
        end
    endtask

    // One clock: drive at negedge, then check and advance the model 1ns later.
    task automatic step();
        beat_t   hb;
        bit      hs;
        logic [1:0] req;
        @(negedge clk);
        if (flush) begin
            q0.delete();
            q1.delete();
            s0_axis_tvalid = 1'b0;
            s1_axis_tvalid = 1'b0;
            hs0 = 1'b0;
            hs1 = 1'b0;
            flush = 1'b0;
        end
        if (hs0) begin q0.delete(0); s0_axis_tvalid = 1'b0; hs0 = 1'b0; end
        if (hs1) begin q1.delete(0); s1_axis_tvalid = 1'b0; hs1 = 1'b0; end
        if (!s0_axis_tvalid && q0.size() > 0 && (!rnd_vld || $urandom_range(0, 3) != 0)) begin
            s0_axis_tvalid = 1'b1;
            {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast} = q0[0];
        end
        if (!s1_axis_tvalid && q1.size() > 0 && (!rnd_vld || $urandom_range(0, 3) != 0)) begin
            s1_axis_tvalid = 1'b1;
            {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast} = q1[0];
        end
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
            default: m_axis_tready = ($urandom_range(0, 2) != 0);
        endcase
        pat_idx++;
        if (rnd_en && $urandom_range(0, 19) == 0) en_v = 2'($urandom_range(0, 3));
        port_en    = en_v;
        axis_reset = rst_req;
        if (clr_on_last)
            cnt_clear = busy_m && !port_m && s0_axis_tvalid && s0_axis_tlast && m_axis_tready;
        else
            cnt_clear = rnd_clr && ($urandom_range(0, 39) == 0);
        #1;
        if (axis_reset) begin
            busy_m = 1'b0; last_m = 1'b1; cnt0_m = 0; cnt1_m = 0; fwd_beats = 0;
            flush = 1'b1;
        end else begin
            chk("busy", 64'(busy), 64'(busy_m));
            chk("grant", 64'(grant), 64'(busy_m ? port_m : last_m));
            chk("pkt_cnt0", 64'(pkt_cnt0), 64'(cnt0_m));
            chk("pkt_cnt1", 64'(pkt_cnt1), 64'(cnt1_m));
            if (!busy_m) begin
                chk("m_tvalid_idle", 64'(m_axis_tvalid), 64'd0);
                chk("s0_tready_idle", 64'(s0_axis_tready), 64'd0);
                chk("s1_tready_idle", 64'(s1_axis_tready), 64'd0);
                req = {s1_axis_tvalid & en_v[1], s0_axis_tvalid & en_v[0]};
                if (req != 2'b00) begin
                    port_m = last_m ? !req[0] : req[1];
                    busy_m = 1'b1;
                end
                if (cnt_clear) begin cnt0_m = 0; cnt1_m = 0; end
            end else begin
                hs = port_m ? s1_axis_tvalid : s0_axis_tvalid;
                chk("m_tvalid", 64'(m_axis_tvalid), 64'(hs));
                chk("s0_tready", 64'(s0_axis_tready), 64'(!port_m && m_axis_tready));
                chk("s1_tready", 64'(s1_axis_tready), 64'(port_m && m_axis_tready));
                if (hs) begin
                    hb = port_m ? q1[0] : q0[0];
                    chk("m_beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}), 64'(hb));
                end
                if (hs && m_axis_tready) begin
                    if (port_m) hs1 = 1'b1;
                    else        hs0 = 1'b1;
                    fwd_beats++;
                    if (hb.l) begin
                        if (port_m) cnt1_m = (cnt1_m + 1) % (1 << CW);
                        else        cnt0_m = (cnt0_m + 1) % (1 << CW);
                        last_m    = port_m;
                        busy_m    = 1'b0;
                        fwd_beats = 0;
                    end
                end
                if (cnt_clear) begin cnt0_m = 0; cnt1_m = 0; end
            end
        end
    endtask

    task automatic run_until_idle(input int max_cyc);
        int c = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy_m) && c < max_cyc) begin
            step();
            c++;
        end
        if (c >= max_cyc) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        axis_reset = 1'b1; port_en = 2'b11; cnt_clear = 1'b0; m_axis_tready = 1'b1;
        s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
        s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tuser = '0; s0_axis_tlast = 1'b0;
        s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tuser = '0; s1_axis_tlast = 1'b0;

        rst_req = 1'b1;
        repeat (3) step();
        rst_req = 1'b0;
        repeat (2) step();

        // Lone port-0 packet, always ready.
        push_pkt(1'b0, 3);
        run_until_idle(50);
        chk("p0_alone_cnt", 64'(pkt_cnt0), 64'd1);
        chk("p0_alone_grant", 64'(grant), 64'd0);

        // Both ports back-to-back 2-beat packets: alternation comes from the model.
        for (int i = 0; i < 2; i++) begin push_pkt(1'b0, 2); push_pkt(1'b1, 2); end
        run_until_idle(100);

        // Port-1 4-beat packet under a 1,0,0,1 ready pattern.
        rdy_mode = 1; pat_idx = 0;
        push_pkt(1'b1, 4);
        run_until_idle(100);
        rdy_mode = 0;

        // Only port 1 enabled; drop its enable mid-packet.
        en_v = 2'b10;
        push_pkt(1'b0, 3); push_pkt(1'b1, 3); push_pkt(1'b1, 3);
        for (int c = 0; c < 50 && !(busy_m && port_m && fwd_beats == 1); c++) step();
        en_v = 2'b00;
        repeat (40) step();
        chk("en_mask_q0_held", 64'(q0.size()), 64'd3);
        en_v = 2'b11;
        run_until_idle(200);

        // Counter wrap on port 0 with random gaps and backpressure.
        rnd_vld = 1'b1; rdy_mode = 2;
        for (int i = 0; i < 17; i++) push_pkt(1'b0, $urandom_range(1, 3));
        push_pkt(1'b1, 2);
        run_until_idle(2000);

        // Clear coinciding with a port-0 tlast handshake.
        rnd_vld = 1'b0; rdy_mode = 0; clr_on_last = 1'b1;
        push_pkt(1'b0, 2);
        run_until_idle(50);
        clr_on_last = 1'b0;
        chk("clear_wins", 64'(pkt_cnt0), 64'd0);

        // Reset on beat 2 of a 4-beat packet, then a fresh packet.
        push_pkt(1'b0, 4);
        for (int c = 0; c < 50 && !(busy_m && fwd_beats == 1); c++) step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        push_pkt(1'b0, 2);
        run_until_idle(50);
        chk("after_rst_cnt0", 64'(pkt_cnt0), 64'd1);

        // Long random mix: gaps, backpressure, enable toggling, stray clears.
        rnd_vld = 1'b1; rdy_mode = 2; rnd_en = 1'b1; rnd_clr = 1'b1;
        for (int i = 0; i < 120; i++) push_pkt(1'($urandom_range(0, 1)), $urandom_range(1, 5));
        repeat (1500) step();
        rnd_en = 1'b0; en_v = 2'b11;
        run_until_idle(8000);
        rnd_clr = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arp_crypto_input_arbiter.md
Name: arp_crypto_input_arbiter

Overview:
- Packet-atomic, two-input round-robin arbiter feeding the arp_crypto ingress.
- Merges the ARP-request stream (port 0) and the bypass/CPU-injected stream (port 1) onto one AXI-Stream interface.
- Grant is held from the first beat to the tlast beat, so packets never interleave.
- Per-port enable masks and packet counters are exposed for the register block.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width for all streams.
- C_AXIS_TUSER_WIDTH, 128, tuser width for all streams.
- C_CNT_WIDTH, 32, width of each per-port packet counter.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_reset  in  1  synchronous reset, active-high.
- s0_axis_tdata  in  C_AXIS_DATA_WIDTH  port 0 data.
- s0_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  port 0 byte enables.
- s0_axis_tuser  in  C_AXIS_TUSER_WIDTH  port 0 metadata.
- s0_axis_tvalid  in  1  port 0 valid.
- s0_axis_tready  out  1  port 0 ready.
- s0_axis_tlast  in  1  port 0 end of packet.
- s1_axis_* (tdata/tkeep/tuser/tvalid/tready/tlast)  same widths and directions as port 0  port 1 stream.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged data.
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  merged byte enables.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  merged metadata.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  merged end of packet.
- port_en  in  2  per-port arbitration enable, bit i = port i.
- cnt_clear  in  1  synchronous clear of both counters.
- pkt_cnt0  out  C_CNT_WIDTH  packets forwarded from port 0.
- pkt_cnt1  out  C_CNT_WIDTH  packets forwarded from port 1.
- grant  out  1  currently or last granted port index.
- busy  out  1  high while in state PKT.

Behaviour:

States and grant selection:
- Two states: IDLE and PKT.
- Register last_grant; reset value 1, so port 0 wins the first contention.
- req[i] = si_axis_tvalid & port_en[i].
- In IDLE: if req nonzero, grant is registered as the first requester scanning from (last_grant+1) mod 2, and the state moves to PKT. This costs one bubble cycle per packet, with no output beat in IDLE.
- In IDLE: m_axis_tvalid = 0 and both s*_axis_tready = 0.
- In PKT: m_axis_* = s[grant]_axis_* (combinational mux), and s[grant]_axis_tready = m_axis_tready. The non-granted tready is 0.
- PKT -> IDLE on the beat where m_axis_tvalid & m_axis_tready & m_axis_tlast. On that beat last_grant <= grant.

Mid-packet conditions:
- Granted tvalid low mid-packet: m_axis_tvalid = 0 and the state stays PKT. There is no timeout and no regrant.
- Clearing port_en for the granted port mid-packet does not abort the packet; the mask takes effect only in IDLE.
- Single-beat packets (tlast on the first beat) are legal: IDLE -> PKT -> IDLE, one beat forwarded.

Counters:
- pkt_cnti increments by 1 on each completed tlast handshake from port i.
- Counters wrap from all-ones to 0.
- If cnt_clear and an increment occur in the same cycle, clear wins and the counter is 0.

Reset:
- Reset values: state IDLE, m_axis_tvalid 0, s0/s1 tready 0, pkt_cnt0/1 0, grant 1 (mirrors last_grant), busy 0.
- Reset asserted mid-packet forces IDLE on the next edge. The partial packet is abandoned, with no tlast generated.
- Upstream must also be reset by the same signal.

Handshake rules:
- Output data is stable while m_axis_tvalid & !m_axis_tready, because the upstream AXIS hold rule passes through the mux.
- Latency is 1 cycle from request to first output-valid; zero added latency per beat afterwards.

Test Plan:
- Port 0 alone sends a 3-beat packet, m_axis_tready = 1 -> exactly 3 output beats with tlast on beat 3; pkt_cnt0 = 1; grant = 0; returns to IDLE.
- Both ports hold 2-beat packets continuously after reset -> output packet order 0,1,0,1; each packet complete before the next; pkt_cnt0 = pkt_cnt1 = 2 after 4 packets.
- Downstream applies a tready low/high pattern (1,0,0,1,...) during a port-1 4-beat packet -> no beat lost or duplicated; s1_axis_tready mirrors m_axis_tready; s0_axis_tready stays 0 throughout.
- port_en = 2'b10 with both ports requesting -> only port 1 is served. Clear port_en[1] mid-packet -> that packet still completes, then no further grants.
- Preload pkt_cnt0 to all-ones via repeated traffic or force, then complete one port-0 packet -> 0. Assert cnt_clear on the same cycle as a tlast handshake -> counter reads 0.
- Assert axis_reset on beat 2 of a 4-beat packet -> next cycle m_axis_tvalid = 0, both tready = 0, busy = 0, counters 0. A fresh port-0 packet afterwards is granted normally.
